// File: rtl/mem_stage_if.sv
// EX/MEM -> memory stage -> MEM/WB signal bundle.
// master drives the EX/MEM side; slave is the memory stage.
interface mem_stage_if;
  logic [31:0] data_1_in;
  logic [31:0] data_2_in;
  logic [4:0]  Rd_in;
  logic        MEM_wen_in;
  logic        WB_sel_in;
  logic        Reg_WB_in;
  logic        stall_out;
  logic [31:0] wb_data_out;
  logic [4:0]  Rd_out;
  logic        Reg_WB_out;
  logic        misalign_out;

  modport master (
    output data_1_in, data_2_in, Rd_in, MEM_wen_in, WB_sel_in, Reg_WB_in,
    input  stall_out, wb_data_out, Rd_out, Reg_WB_out, misalign_out
  );

  modport slave (
    input  data_1_in, data_2_in, Rd_in, MEM_wen_in, WB_sel_in, Reg_WB_in,
    output stall_out, wb_data_out, Rd_out, Reg_WB_out, misalign_out
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-organised data memory with LAT extra
// cycles per access, stalling EX/MEM while busy and registering MEM/WB.
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);
  localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        wb_data_reg;
  logic [4:0]         rd_reg;
  logic               reg_wb_reg;
  logic               misalign_reg;

  logic [31:0]        mem [DEPTH];

  logic [ADDR_W-1:0]  idx;
  logic               mem_op;
  logic               complete;
  logic               stall;

  assign idx    = bus.data_1_in[ADDR_W+1:2];
  assign mem_op = bus.MEM_wen_in | bus.WB_sel_in;

  // complete: the access finishes at the coming edge; stall: a bubble is issued instead
  always_comb begin
    complete = 1'b0;
    stall    = 1'b0;
    if (LAT == 0) begin
      complete = mem_op;
    end else if (state_reg == IDLE) begin
      stall = mem_op;
    end else if (cnt_reg == '0) begin
      complete = 1'b1;
    end else begin
      stall = 1'b1;
    end
  end

  assign bus.stall_out    = stall & reset;
  assign bus.wb_data_out  = wb_data_reg;
  assign bus.Rd_out       = rd_reg;
  assign bus.Reg_WB_out   = reg_wb_reg;
  assign bus.misalign_out = misalign_reg;

  // Write port has no reset so it maps onto block RAM; gating with reset drops aborted stores
  always_ff @(posedge clk) begin
    if (complete && bus.MEM_wen_in && reset) begin
      mem[idx] <= bus.data_2_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      wb_data_reg  <= '0;
      rd_reg       <= '0;
      reg_wb_reg   <= 1'b0;
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= 1'b0;
      if (complete) begin
        state_reg    <= IDLE;
        rd_reg       <= bus.Rd_in;
        misalign_reg <= |bus.data_1_in[1:0];
        if (bus.MEM_wen_in) begin
          wb_data_reg <= bus.data_1_in;
          reg_wb_reg  <= 1'b0;
        end else begin
          wb_data_reg <= mem[idx];
          reg_wb_reg  <= bus.Reg_WB_in;
        end
      end else if (stall) begin
        rd_reg     <= '0;
        reg_wb_reg <= 1'b0;
        if (state_reg == IDLE) begin
          state_reg <= BUSY;
          cnt_reg   <= CNT_W'(LAT - 1);
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end else begin
        wb_data_reg <= bus.data_1_in;
        rd_reg      <= bus.Rd_in;
        reg_wb_reg  <= bus.Reg_WB_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a LAT=2 instance and a LAT=0 instance
// checked against a plain array model of each data memory.
module tb_mem_stage;
  localparam int LAT_A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus_a ();
  mem_stage_if bus_b ();

  mem_stage #(.DEPTH(256), .ADDR_W(8), .LAT(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  mem_stage #(.DEPTH(256), .ADDR_W(8), .LAT(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;
  int op_no  = 0;
  logic [31:0] model [2][256];
  bit          valid [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic st, input logic ld,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rwb);
    if (which == 0) begin
      bus_a.MEM_wen_in = st; bus_a.WB_sel_in = ld; bus_a.data_1_in = a;
      bus_a.data_2_in = d; bus_a.Rd_in = rd; bus_a.Reg_WB_in = rwb;
    end else begin
      bus_b.MEM_wen_in = st; bus_b.WB_sel_in = ld; bus_b.data_1_in = a;
      bus_b.data_2_in = d; bus_b.Rd_in = rd; bus_b.Reg_WB_in = rwb;
    end
  endtask

  task automatic sample(input int which, output logic s, output logic [31:0] wb,
                        output logic [4:0] r, output logic w, output logic m);
    if (which == 0) begin
      s = bus_a.stall_out; wb = bus_a.wb_data_out; r = bus_a.Rd_out;
      w = bus_a.Reg_WB_out; m = bus_a.misalign_out;
    end else begin
      s = bus_b.stall_out; wb = bus_b.wb_data_out; r = bus_b.Rd_out;
      w = bus_b.Reg_WB_out; m = bus_b.misalign_out;
    end
  endtask

  // One complete transaction, entered and left at a falling edge with the stage idle
  task automatic run(input int which, input logic st, input logic ld,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [4:0] rd, input logic rwb);
    int lat;
    int idx;
    logic memop;
    logic s, w, m;
    logic [31:0] wb;
    logic [4:0] r;
    lat   = (which == 0) ? LAT_A : 0;
    idx   = int'((a >> 2) % 256);
    memop = st | ld;
    drive(which, st, ld, a, d, rd, rwb);
    #1;
    sample(which, s, wb, r, w, m);
    chk("stall_first", {31'd0, s}, {31'd0, memop && (lat > 0)});
    if (memop) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        sample(which, s, wb, r, w, m);
        chk("stall_busy", {31'd0, s}, {31'd0, k < lat});
        chk("bubble_rwb", {31'd0, w}, 32'd0);
        chk("bubble_rd", {27'd0, r}, 32'd0);
        chk("bubble_mis", {31'd0, m}, 32'd0);
      end
    end
    @(negedge clk);
    sample(which, s, wb, r, w, m);
    chk("result_rd", {27'd0, r}, {27'd0, rd});
    chk("result_mis", {31'd0, m}, {31'd0, memop && (a[1:0] != 2'b00)});
    if (st) begin
      chk("store_rwb", {31'd0, w}, 32'd0);
      model[which][idx] = d;
      valid[which][idx] = 1'b1;
    end else begin
      chk("result_rwb", {31'd0, w}, {31'd0, rwb});
      chk("result_wb", wb, ld ? model[which][idx] : a);
    end
    $display("op %0d dut=%0d st=%0b ld=%0b addr=%h data=%h rd=%0d wb_out=%h",
             op_no, which, st, ld, a, d, rd, wb);
    op_no++;
    drive(which, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  function automatic int pick_valid(input int which);
    int start;
    start = int'($urandom_range(0, 255));
    for (int i = 0; i < 256; i++) begin
      if (valid[which][(start + i) % 256]) return (start + i) % 256;
    end
    return -1;
  endfunction

  initial begin
    logic s, w, m;
    logic [31:0] wb;
    logic [4:0] r;

    // Reset held with a store presented: nothing may stall or write
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h20, 32'h11, 5'd3, 1'b1);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    sample(0, s, wb, r, w, m);
    chk("rst_stall", {31'd0, s}, 32'd0);
    chk("rst_wb", wb, 32'd0);
    chk("rst_rd", {27'd0, r}, 32'd0);
    chk("rst_rwb", {31'd0, w}, 32'd0);
    chk("rst_mis", {31'd0, m}, 32'd0);
    reset = 1'b1;
    run(0, 1'b1, 1'b0, 32'h20, 32'h11, 5'd3, 1'b1);

    // Directed cases
    run(0, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd5, 1'b1);
    run(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 5'd2, 1'b1);
    run(0, 1'b0, 1'b1, 32'h10, 32'd0, 5'd7, 1'b1);
    run(0, 1'b1, 1'b0, 32'h400, 32'h55, 5'd1, 1'b0);
    run(0, 1'b0, 1'b1, 32'h0, 32'd0, 5'd9, 1'b1);
    run(0, 1'b0, 1'b1, 32'h13, 32'd0, 5'd4, 1'b1);
    run(0, 1'b1, 1'b1, 32'h22, 32'hCAFE0001, 5'd6, 1'b1);
    run(0, 1'b0, 1'b1, 32'h20, 32'd0, 5'd8, 1'b1);
    run(1, 1'b1, 1'b0, 32'h8, 32'hA5A5F00D, 5'd2, 1'b0);
    run(1, 1'b0, 1'b1, 32'h8, 32'd0, 5'd10, 1'b1);

    // Reset during the final busy cycle of a store: the store must be lost
    run(0, 1'b1, 1'b0, 32'h40, 32'h0BADF00D, 5'd0, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h40, 32'h12345678, 5'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    sample(0, s, wb, r, w, m);
    chk("midrst_stall", {31'd0, s}, 32'd0);
    chk("midrst_wb", wb, 32'd0);
    chk("midrst_rwb", {31'd0, w}, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    run(0, 1'b0, 1'b1, 32'h40, 32'd0, 5'd11, 1'b1);

    // Randomized mix on both latencies
    for (int i = 0; i < 40; i++) begin
      int which;
      int kind;
      int idx;
      logic [31:0] a;
      which = int'($urandom_range(0, 1));
      kind  = int'($urandom_range(0, 2));
      idx   = pick_valid(which);
      if (kind == 2 && idx < 0) kind = 1;
      if (kind != 2) idx = int'($urandom_range(0, 255));
      a = ($urandom & 32'hFFFFFC03) | (32'(idx) << 2);
      case (kind)
        0: run(which, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'($urandom));
        1: run(which, 1'b1, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom));
        default: run(which, 1'b0, 1'b1, a, $urandom, 5'($urandom), 1'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage that sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It performs loads and stores against an internal word-organised data memory with a configurable access latency. While an access is in flight it stalls the EX/MEM register. Its registered outputs form the MEM/WB boundary that feeds write-back.

Parameters:
DEPTH, 256, number of 32-bit data-memory words (power of two)
ADDR_W, 8, word-index width; must equal log2(DEPTH)
LAT, 2, extra cycles a load/store occupies; 0 = single-cycle, no stall

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
data_1_in  in  32  ALU result / byte address from EX/MEM
data_2_in  in  32  store data from EX/MEM
Rd_in  in  5  destination register
MEM_wen_in  in  1  store request
WB_sel_in  in  1  1 = load (write-back memory data), 0 = write back ALU result
Reg_WB_in  in  1  register write enable
stall_out  out  1  to EX/MEM stall input; holds the current instruction
wb_data_out  out  32  MEM/WB write-back data
Rd_out  out  5  MEM/WB destination register
Reg_WB_out  out  1  MEM/WB register write enable
misalign_out  out  1  one-cycle flag: completed access had addr[1:0] != 0

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, counter=0, wb_data_out=0, Rd_out=0, Reg_WB_out=0, misalign_out=0. Memory contents are not cleared. A reset mid-access abandons the access; a pending store is not written.
- Memory op definition: mem_op = MEM_wen_in | WB_sel_in. Store has priority when both are set. A store forces Reg_WB_out=0 at completion.
- Memory index = data_1_in[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words. Low two bits are ignored for indexing and only drive misalign_out.
- States: IDLE, BUSY. The counter is ceil(log2(LAT+1)) bits wide.
- IDLE, non-mem op:
  - Registered pass-through in one cycle: wb_data_out<=data_1_in, Rd_out<=Rd_in, Reg_WB_out<=Reg_WB_in.
  - stall_out=0.
- IDLE, mem op, LAT=0:
  - Access completes at this edge; no stall.
  - Store: mem[idx]<=data_2_in.
  - Load: wb_data_out<=mem[idx] (pre-edge contents).
- IDLE, mem op, LAT>0:
  - stall_out=1 combinationally.
  - Next state BUSY with counter<=LAT-1.
  - Bubble at the edge: Reg_WB_out<=0, Rd_out<=0, wb_data_out holds.
- BUSY, counter != 0:
  - stall_out=1, counter decrements, bubble as above.
- BUSY, counter == 0:
  - stall_out=0, so EX/MEM advances at this edge.
  - The access completes at this edge using the held EX/MEM inputs; output register updates as in the single-cycle case.
  - Next state IDLE.
- Mem-op timing for LAT=L>0:
  - stall_out is high for exactly L cycles.
  - The result appears L+1 edges after the op first arrives.
  - Throughput is one mem op per L+1 cycles.
- misalign_out: asserted for one cycle, with the completing result, when the completed mem op had data_1_in[1:0] != 0. Otherwise 0.
- Back-to-back mem ops: the second is seen in IDLE on the cycle after completion and starts its own full latency. No overlap.
- Stall, bubble and state are determined only by this block. Input changes while stall_out=1 are an upstream error and are not checked.

Test Plan:
1. Reset: hold reset=0 two cycles with mem op on inputs -> all outputs 0, stall_out=0; release -> op starts normally.
2. Pass-through: data_1_in=0x1234, Rd_in=5, Reg_WB_in=1, WB_sel=MEM_wen=0 -> next edge wb_data_out=0x1234, Rd_out=5, Reg_WB_out=1, stall_out never high.
3. Store then load, LAT=2:
   - Store addr 0x10, data 0xDEADBEEF -> stall_out high 2 cycles, Reg_WB_out=0 throughout.
   - Load addr 0x10, Rd=7 -> stall 2 cycles, then wb_data_out=0xDEADBEEF, Rd_out=7, Reg_WB_out=1 for one cycle.
4. Wrap and misalign, DEPTH=256:
   - Store 0x55 at addr 0x400 -> load from addr 0x0 returns 0x55.
   - Load addr 0x13 -> returns word at index 4, misalign_out=1 for one cycle.
5. LAT=0 build: store/load at addr 0x8 on consecutive cycles -> no stall; load returns the stored value.
6. Reset mid-access: store issued, reset pulsed low during the BUSY cycle -> state IDLE, stall_out=0; a later load of that address returns the prior contents, not the aborted store data.
